// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - out-of-order issue queue with age-matrix oldest-ready select
// Entries wait in slots until both sources are ready; one issues per cycle through a register.
package issue_queue_pkg;
  localparam int DISPATCH_WIDTH = 2;
  localparam int WB_WIDTH       = 2;
  localparam int PHY_REG_NUM    = 64;
  localparam int PREG_W         = $clog2(PHY_REG_NUM);

  typedef struct packed {
    logic [15:0]       tag;
    logic [PREG_W-1:0] pdest;
    logic [PREG_W-1:0] src0;
    logic              src0_ready;
    logic [PREG_W-1:0] src1;
    logic              src1_ready;
  } DqEntrySt;
endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [DISPATCH_WIDTH-1:0]           dq_valid_i,
  input  DqEntrySt [DISPATCH_WIDTH-1:0]       dq_data_i,
  output logic [DISPATCH_WIDTH-1:0]           dq_ready_o,
  input  logic [WB_WIDTH-1:0]                 wb_i,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]     wb_pdest_i,
  output logic                                issue_valid_o,
  output DqEntrySt                            issue_data_o,
  input  logic                                issue_ready_i
);
  localparam int CNT_W  = $clog2(IQ_DEPTH + 1);
  localparam int LANE_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  logic [IQ_DEPTH-1:0]                valid_q, valid_d;
  DqEntrySt [IQ_DEPTH-1:0]            slot_q, slot_d, slot_woken;
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]  older_q, older_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d, free_cnt, acc_cnt;
  logic [DISPATCH_WIDTH-1:0]          accept;
  DqEntrySt [DISPATCH_WIDTH-1:0]      in_woken;
  logic [IQ_DEPTH-1:0]                is_new, cand, grant;
  logic [IQ_DEPTH-1:0][LANE_W-1:0]    new_lane;
  logic                               load, take;
  DqEntrySt                           grant_data;

  function automatic DqEntrySt wake(input DqEntrySt e,
                                    input logic [WB_WIDTH-1:0] v,
                                    input logic [WB_WIDTH-1:0][PREG_W-1:0] p);
    DqEntrySt r;
    r = e;
    for (int j = 0; j < WB_WIDTH; j++) begin
      if (v[j] && (e.src0 == p[j])) r.src0_ready = 1'b1;
      if (v[j] && (e.src1 == p[j])) r.src1_ready = 1'b1;
    end
    return r;
  endfunction

  // Ready depends on registered occupancy only; slots freed by this cycle's issue are not counted.
  assign free_cnt = CNT_W'(IQ_DEPTH) - cnt_q;
  for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_ready
    assign dq_ready_o[k] = !flush_i && (free_cnt > CNT_W'(k));
  end
  assign accept = dq_valid_i & dq_ready_o;

  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) in_woken[k] = wake(dq_data_i[k], wb_i, wb_pdest_i);
    for (int i = 0; i < IQ_DEPTH; i++) slot_woken[i] = wake(slot_q[i], wb_i, wb_pdest_i);
  end

  always_comb begin
    acc_cnt = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) acc_cnt = acc_cnt + CNT_W'(accept[k]);
  end

  // Lane k lands in the k-th lowest-index free slot.
  always_comb begin
    logic [CNT_W-1:0] rank;
    rank     = '0;
    is_new   = '0;
    new_lane = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (!valid_q[i]) begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (accept[k] && (rank == CNT_W'(k))) begin
            is_new[i]   = 1'b1;
            new_lane[i] = LANE_W'(k);
          end
        end
        rank = rank + CNT_W'(1);
      end
    end
  end

  always_comb begin
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      cand[i] = valid_q[i] && slot_q[i].src0_ready && slot_q[i].src1_ready;
    end
    for (int i = 0; i < IQ_DEPTH; i++) begin
      grant[i] = cand[i];
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (cand[j] && older_q[j][i]) grant[i] = 1'b0;
      end
    end
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (grant[i]) grant_data = slot_q[i];
    end
  end

  assign load = !issue_valid_o || issue_ready_i;
  assign take = load && (|grant);

  // Stale age bits of empty slots are harmless: candidates are always valid and rows are rewritten on allocation.
  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_woken;
    older_d = older_q;
    if (take) valid_d = valid_q & ~grant;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (is_new[i]) begin
        valid_d[i] = 1'b1;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (new_lane[i] == LANE_W'(k)) slot_d[i] = in_woken[k];
        end
        for (int j = 0; j < IQ_DEPTH; j++) begin
          older_d[i][j] = is_new[j] && (new_lane[i] < new_lane[j]);
          older_d[j][i] = valid_q[j] || (is_new[j] && (new_lane[j] < new_lane[i]));
        end
      end
    end
    cnt_d = cnt_q + acc_cnt - CNT_W'(take);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      slot_q        <= '0;
      older_q       <= '0;
      cnt_q         <= '0;
      issue_valid_o <= 1'b0;
      issue_data_o  <= '0;
    end else if (flush_i) begin
      valid_q       <= '0;
      slot_q        <= '0;
      older_q       <= '0;
      cnt_q         <= '0;
      issue_valid_o <= 1'b0;
      issue_data_o  <= '0;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
      older_q <= older_d;
      cnt_q   <= cnt_d;
      if (take) begin
        issue_valid_o <= 1'b1;
        issue_data_o  <= grant_data;
      end else if (issue_ready_i) begin
        issue_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - randomized self-checking bench for issue_queue
// The model keeps resident entries in an age-ordered queue and issues the first ready one.
module tb_issue_queue;
  import issue_queue_pkg::*;
  localparam int IQ_DEPTH = 8;

  logic clk = 1'b0;
  logic rst, flush_i, issue_valid_o, issue_ready_i;
  logic [DISPATCH_WIDTH-1:0]          dq_valid_i, dq_ready_o;
  DqEntrySt [DISPATCH_WIDTH-1:0]      dq_data_i;
  logic [WB_WIDTH-1:0]                wb_i;
  logic [WB_WIDTH-1:0][PREG_W-1:0]    wb_pdest_i;
  DqEntrySt                           issue_data_o;

  issue_queue #(.IQ_DEPTH(IQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .dq_valid_i(dq_valid_i), .dq_data_i(dq_data_i), .dq_ready_o(dq_ready_o),
    .wb_i(wb_i), .wb_pdest_i(wb_pdest_i),
    .issue_valid_o(issue_valid_o), .issue_data_o(issue_data_o), .issue_ready_i(issue_ready_i)
  );

  always #5 clk = ~clk;

  int       n_chk = 0;
  int       n_fail = 0;
  DqEntrySt mq[$];
  logic     m_ov;
  DqEntrySt m_od;
  int       m_acc;
  bit       seen[int];
  int       hs_cnt = 0;
  int       next_tag = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic DqEntrySt wake(input DqEntrySt e);
    DqEntrySt r;
    r = e;
    for (int j = 0; j < WB_WIDTH; j++) begin
      if (wb_i[j] && r.src0 == wb_pdest_i[j]) r.src0_ready = 1'b1;
      if (wb_i[j] && r.src1 == wb_pdest_i[j]) r.src1_ready = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [DISPATCH_WIDTH-1:0] model_ready();
    logic [DISPATCH_WIDTH-1:0] r;
    int free;
    free = IQ_DEPTH - mq.size();
    for (int k = 0; k < DISPATCH_WIDTH; k++) r[k] = !flush_i && (free > k);
    return r;
  endfunction

  function automatic DqEntrySt mk(input int s0, input bit r0, input int s1, input bit r1);
    DqEntrySt e;
    e.tag        = 16'(next_tag);
    next_tag++;
    e.pdest      = PREG_W'($urandom_range(0, 63));
    e.src0       = PREG_W'(s0);
    e.src0_ready = r0;
    e.src1       = PREG_W'(s1);
    e.src1_ready = r1;
    return e;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ov = 1'b0;
    m_od = '0;
  endtask

  task automatic compare();
    chk("dq_ready", 64'(dq_ready_o), 64'(model_ready()));
    chk("issue_valid", 64'(issue_valid_o), 64'(m_ov));
    chk("issue_data", 64'(issue_data_o), 64'(m_od));
    if (issue_valid_o && issue_ready_i) begin
      chk("no_duplicate_issue", 64'(seen.exists(int'(issue_data_o.tag))), 64'd0);
      seen[int'(issue_data_o.tag)] = 1'b1;
      hs_cnt++;
    end
  endtask

  task automatic model_step();
    int free, sel;
    m_acc = 0;
    if (flush_i) begin
      model_clear();
      return;
    end
    free = IQ_DEPTH - mq.size();
    if (!m_ov || issue_ready_i) begin
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].src0_ready && mq[i].src1_ready) sel = i;
      if (sel >= 0) begin
        m_od = mq[sel];
        m_ov = 1'b1;
        mq.delete(sel);
      end else begin
        m_ov = 1'b0;
      end
    end
    foreach (mq[i]) mq[i] = wake(mq[i]);
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (dq_valid_i[k] && free > k) begin
        mq.push_back(wake(dq_data_i[k]));
        m_acc++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dq_valid_i = '0;
    dq_data_i  = '0;
    wb_i       = '0;
    wb_pdest_i = '0;
  endtask

  task automatic rand_wb(input int maxp);
    for (int j = 0; j < WB_WIDTH; j++) begin
      wb_i[j]       = 1'($urandom_range(0, 1));
      wb_pdest_i[j] = PREG_W'($urandom_range(0, maxp));
    end
  endtask

  task automatic drain(input string name);
    idle();
    issue_ready_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (mq.size() == 0 && !m_ov) break;
      wb_i = '1;
      for (int j = 0; j < WB_WIDTH; j++) wb_pdest_i[j] = PREG_W'((c * WB_WIDTH + j) % 64);
      cycle();
    end
    idle();
    chk({name, "_drained_valid"}, 64'(issue_valid_o), 64'd0);
    chk({name, "_drained_ready"}, 64'(dq_ready_o), 64'd3);
  endtask

  task automatic load_flush_scene();
    issue_ready_i = 1'b0;
    dq_data_i[0] = mk(1, 1'b1, 1, 1'b1);
    dq_data_i[1] = mk(60, 1'b0, 0, 1'b1);
    dq_valid_i = '1;
    cycle();
    for (int c = 0; c < 2; c++) begin
      dq_data_i[0] = mk(60, 1'b0, 0, 1'b1);
      dq_data_i[1] = mk(61, 1'b0, 0, 1'b1);
      cycle();
    end
    idle();
  endtask

  initial begin
    DqEntrySt e;
    DqEntrySt pend[$];
    int tag_a, tag3, tag6, tag_s, hs0, n;

    rst = 1'b1;
    flush_i = 1'b0;
    issue_ready_i = 1'b0;
    idle();
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_dq_ready", 64'(dq_ready_o), 64'd3);
    chk("reset_issue_valid", 64'(issue_valid_o), 64'd0);
    chk("reset_issue_data", 64'(issue_data_o), 64'd0);

    // Minimum latency: accept at edge 1, visible after edge 2.
    e = mk(1, 1'b1, 2, 1'b1);
    tag_a = int'(e.tag);
    dq_data_i[0] = e;
    dq_valid_i = 2'b01;
    cycle();
    idle();
    chk("lat_edge1_valid", 64'(issue_valid_o), 64'd0);
    cycle();
    chk("lat_edge2_valid", 64'(issue_valid_o), 64'd1);
    chk("lat_edge2_tag", 64'(issue_data_o.tag), 64'(tag_a));
    issue_ready_i = 1'b1;
    cycle();
    chk("lat_after_valid", 64'(issue_valid_o), 64'd0);
    chk("lat_after_ready", 64'(dq_ready_o), 64'd3);

    // Fill with non-ready entries under backpressure.
    issue_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) dq_data_i[k] = mk(40 + 2 * c + k, 1'b0, 0, 1'b1);
      dq_valid_i = '1;
      cycle();
      if (c == 3) chk("fill_full_ready", 64'(dq_ready_o), 64'd0);
    end
    idle();
    chk("fill_no_issue", 64'(issue_valid_o), 64'd0);
    chk("fill_still_full", 64'(dq_ready_o), 64'd0);
    drain("fill");

    // Wakeup ordering: 3rd and 6th allocated share src0 = 5.
    issue_ready_i = 1'b1;
    tag3 = 0;
    tag6 = 0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        n = 2 * c + k + 1;
        e = mk((n == 3 || n == 6) ? 5 : 48 + n, 1'b0, 0, 1'b1);
        if (n == 3) tag3 = int'(e.tag);
        if (n == 6) tag6 = int'(e.tag);
        dq_data_i[k] = e;
      end
      dq_valid_i = '1;
      cycle();
    end
    idle();
    chk("wo_full", 64'(dq_ready_o), 64'd0);
    wb_i = 2'b01;
    wb_pdest_i[0] = PREG_W'(5);
    cycle();
    idle();
    chk("wo_c1_valid", 64'(issue_valid_o), 64'd0);
    cycle();
    chk("wo_first_valid", 64'(issue_valid_o), 64'd1);
    chk("wo_first_tag", 64'(issue_data_o.tag), 64'(tag3));
    cycle();
    chk("wo_second_valid", 64'(issue_valid_o), 64'd1);
    chk("wo_second_tag", 64'(issue_data_o.tag), 64'(tag6));
    drain("wo");

    // Same-cycle wakeup of an incoming entry.
    e = mk(1, 1'b1, 9, 1'b0);
    tag_s = int'(e.tag);
    dq_data_i[0] = e;
    dq_valid_i = 2'b01;
    wb_i = 2'b01;
    wb_pdest_i[0] = PREG_W'(9);
    cycle();
    idle();
    chk("scw_edge1_valid", 64'(issue_valid_o), 64'd0);
    cycle();
    chk("scw_edge2_valid", 64'(issue_valid_o), 64'd1);
    chk("scw_edge2_tag", 64'(issue_data_o.tag), 64'(tag_s));
    chk("scw_src1_ready", 64'(issue_data_o.src1_ready), 64'd1);
    drain("scw");

    // Backpressure: 20 entries, toggling issue_ready_i.
    for (int i = 0; i < 20; i++)
      pend.push_back(mk($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 7), 1'($urandom_range(0, 1))));
    hs0 = hs_cnt;
    for (int c = 0; c < 400; c++) begin
      if (pend.size() == 0 && mq.size() == 0 && !m_ov) break;
      dq_valid_i = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (k < pend.size()) begin
          dq_valid_i[k] = 1'b1;
          dq_data_i[k] = pend[k];
        end
      end
      rand_wb(7);
      issue_ready_i = 1'($urandom_range(0, 1));
      cycle();
      repeat (m_acc) void'(pend.pop_front());
    end
    chk("bp_all_issued", 64'(hs_cnt - hs0), 64'd20);
    drain("bp");

    // Flush with five resident entries and a held output.
    load_flush_scene();
    chk("fl_out_valid", 64'(issue_valid_o), 64'd1);
    flush_i = 1'b1;
    #1;
    chk("fl_ready_low", 64'(dq_ready_o), 64'd0);
    cycle();
    flush_i = 1'b0;
    #1;
    chk("fl_after_valid", 64'(issue_valid_o), 64'd0);
    chk("fl_after_data", 64'(issue_data_o), 64'd0);
    chk("fl_after_ready", 64'(dq_ready_o), 64'd3);

    // Asynchronous reset mid-burst.
    load_flush_scene();
    chk("rst_pre_valid", 64'(issue_valid_o), 64'd1);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_async_valid", 64'(issue_valid_o), 64'd0);
    chk("rst_async_data", 64'(issue_data_o), 64'd0);
    chk("rst_async_ready", 64'(dq_ready_o), 64'd3);
    #1;
    rst = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      n = $urandom_range(0, DISPATCH_WIDTH);
      dq_valid_i = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        dq_data_i[k] = mk($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        if (k < n) dq_valid_i[k] = 1'b1;
      end
      rand_wb(15);
      issue_ready_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 63) == 0);
      cycle();
    end
    flush_i = 1'b0;
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
